instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 168 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches 18-bit instructions, decodes them and
// steps the datapath strobes through FETCH / DECODE / EXEC / MEM / WB.
module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        mem_req,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  input  logic        mem_ack,
  input  logic [17:0] instr_in,
  output logic [9:0]  pc,
  output logic [17:0] ir,
  output logic [3:0]  alu_select,
  output logic        alu_imm,
  output logic [3:0]  rf_r1,
  output logic [3:0]  rf_r2,
  output logic [3:0]  rf_waddr,
  output logic        rf_we,
  output logic        wb_sel,
  input  logic [1:0]  flags,
  output logic        flag_we,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_ANDI = 4'b0101;
  localparam logic [3:0] OP_LD   = 4'b0110;
  localparam logic [3:0] OP_ST   = 4'b0111;
  localparam logic [3:0] OP_CMP  = 4'b1000;
  localparam logic [3:0] OP_JUMP = 4'b1001;
  localparam logic [3:0] OP_JE   = 4'b1010;
  localparam logic [3:0] OP_JA   = 4'b1011;
  localparam logic [3:0] OP_JB   = 4'b1100;
  localparam logic [3:0] OP_JAE  = 4'b1101;
  localparam logic [3:0] OP_JBE  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  state_t      state_reg, state_next;
  logic [9:0]  pc_reg, pc_next;
  logic [17:0] ir_reg, ir_next;
  logic [3:0]  opcode;
  logic [9:0]  target;
  logic [3:0]  alu_dec;
  logic        imm_dec;
  logic        jump_taken;

  assign opcode = ir_reg[17:14];
  assign target = ir_reg[9:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  // ALU operation is a pure function of the opcode, so WB sees the same value EXEC drove.
  always_comb begin
    alu_dec = 4'b0000;
    imm_dec = 1'b0;
    case (opcode)
      OP_ADD:  alu_dec = 4'b0001;
      OP_AND:  alu_dec = 4'b0010;
      OP_NAND: alu_dec = 4'b0100;
      OP_NOR:  alu_dec = 4'b1000;
      OP_ADDI: begin alu_dec = 4'b0001; imm_dec = 1'b1; end
      OP_ANDI: begin alu_dec = 4'b0010; imm_dec = 1'b1; end
      default: begin alu_dec = 4'b0000; imm_dec = 1'b0; end
    endcase
  end

  // flags: 00 above, 01 equal, 10 below; 11 is reserved and never satisfies a condition.
  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JUMP: jump_taken = 1'b1;
      OP_JA:   jump_taken = (flags == 2'b00);
      OP_JE:   jump_taken = (flags == 2'b01);
      OP_JB:   jump_taken = (flags == 2'b10);
      OP_JAE:  jump_taken = (flags == 2'b00) || (flags == 2'b01);
      OP_JBE:  jump_taken = (flags == 2'b01) || (flags == 2'b10);
      default: jump_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    alu_select = 4'b0000;
    alu_imm    = 1'b0;
    rf_we      = 1'b0;
    wb_sel     = 1'b0;
    flag_we    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_reg;
        if (mem_ack) begin
          ir_next    = instr_in;
          pc_next    = pc_reg + 10'd1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        state_next = (opcode == OP_HALT) ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        alu_select = alu_dec;
        alu_imm    = imm_dec;
        case (opcode)
          OP_ADD, OP_AND, OP_NAND, OP_NOR, OP_ADDI, OP_ANDI: state_next = S_WB;
          OP_LD, OP_ST: state_next = S_MEM;
          OP_CMP: begin
            flag_we    = 1'b1;
            state_next = S_FETCH;
          end
          default: begin
            if (jump_taken) pc_next = target;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = target;
        mem_we   = (opcode == OP_ST);
        if (mem_ack) state_next = (opcode == OP_LD) ? S_WB : S_FETCH;
      end
      S_WB: begin
        rf_we      = 1'b1;
        wb_sel     = (opcode == OP_LD);
        alu_select = alu_dec;
        alu_imm    = imm_dec;
        state_next = S_FETCH;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign pc       = pc_reg;
  assign ir       = ir_reg;
  assign busy     = (state_reg != S_IDLE);
  assign rf_waddr = ir_reg[13:10];
  assign rf_r1    = ((opcode == OP_ST) || (opcode == OP_CMP)) ? ir_reg[13:10] : ir_reg[9:6];
  assign rf_r2    = ir_reg[3:0];

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: memory model plus scoreboards for register writes
// and memory accesses, with one task per scenario.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_ack = 1'b0;
  logic [17:0] instr_in = '0;
  logic [1:0]  flags = 2'b00;
  logic        mem_req, mem_we, alu_imm, rf_we, wb_sel, flag_we, busy;
  logic [9:0]  mem_addr, pc;
  logic [17:0] ir;
  logic [3:0]  alu_select, rf_r1, rf_r2, rf_waddr;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .instr_in(instr_in), .pc(pc), .ir(ir),
    .alu_select(alu_select), .alu_imm(alu_imm),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_waddr(rf_waddr), .rf_we(rf_we),
    .wb_sel(wb_sel), .flags(flags), .flag_we(flag_we), .busy(busy)
  );

  always #5 clk = ~clk;

  localparam logic [17:0] HALT = 18'h3C000;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wait_cnt = 0;
  int ack_delay = 0;
  int flag_cnt = 0;
  int start_cyc = 0;
  int wb_cyc = 0;
  logic [9:0]  pc_at_wb = '0;
  bit          acc_chk = 1'b0;
  logic [17:0] prog [1024];
  // {waddr, r1, r2, wb_sel, alu_select, alu_imm}
  logic [17:0] wb_q [$];
  // {we, addr} of every completed memory request
  logic [10:0] acc_q [$];

  function automatic logic [17:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [3:0] rs2);
    return {op, rd, rs1, 2'b00, rs2};
  endfunction

  function automatic logic [17:0] enc_a(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [9:0] addr);
    return {op, rd, addr};
  endfunction

  function automatic logic [17:0] wbe(input logic [3:0] wa, input logic [3:0] r1,
                                      input logic [3:0] r2, input logic ws,
                                      input logic [3:0] alu, input logic imm);
    return {wa, r1, r2, ws, alu, imm};
  endfunction

  // Advance one cycle; at the falling edge check scoreboards and drive the memory model.
  task automatic tick();
    logic [17:0] wb_obs, wb_exp;
    logic [10:0] acc_obs, acc_exp;
    @(negedge clk);
    cyc++;
    if (rf_we) begin
      wb_cyc   = cyc;
      pc_at_wb = pc;
      checks++;
      wb_obs = {rf_waddr, rf_r1, rf_r2, wb_sel, alu_select, alu_imm};
      if (wb_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: observed write %h, expected no write", wb_obs);
      end else begin
        wb_exp = wb_q.pop_front();
        if (wb_obs !== wb_exp) begin
          errors++;
          $display("FAIL wb_fields: observed %h, expected %h", wb_obs, wb_exp);
        end
      end
    end
    if (flag_we) flag_cnt++;
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        instr_in = mem_we ? 18'h0 : prog[mem_addr];
        wait_cnt = 0;
        if (acc_chk) begin
          checks++;
          acc_obs = {mem_we, mem_addr};
          if (acc_q.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected: observed access %h, expected none", acc_obs);
          end else begin
            acc_exp = acc_q.pop_front();
            if (acc_obs !== acc_exp) begin
              errors++;
              $display("FAIL mem_access: observed %h, expected %h", acc_obs, acc_exp);
            end
          end
        end
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = HALT;
  endtask

  // Pulse start and run until idle; busy_cycles is -1 on timeout.
  task automatic run_prog(output int busy_cycles);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    n = 1;
    while (busy === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    busy_cycles = (busy === 1'b1) ? -1 : n - 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: observed %b, expected 0", busy); end
    checks++;
    if (pc !== 10'd0 || ir !== 18'd0) begin
      errors++; $display("FAIL reset_pc_ir: observed pc=%h ir=%h, expected 0/0", pc, ir);
    end
    checks++;
    if ({mem_req, mem_we, rf_we, flag_we, wb_sel, alu_imm, alu_select} !== 10'd0) begin
      errors++;
      $display("FAIL reset_strobes: observed %b, expected all zero",
               {mem_req, mem_we, rf_we, flag_we, wb_sel, alu_imm, alu_select});
    end
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_over_start: observed busy=%b, expected 0", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_hold: observed busy=%b, expected 0", busy); end
  endtask

  task automatic test_add_latency();
    int bc;
    do_reset();
    clear_prog();
    prog[0] = 18'h00000;
    wb_q.push_back(wbe(4'd0, 4'd0, 4'd0, 1'b0, 4'b0001, 1'b0));
    wb_cyc = 0;
    run_prog(bc);
    checks++;
    if (wb_cyc - start_cyc + 1 != 4) begin
      errors++; $display("FAIL add_latency: observed rf_we in cycle %0d, expected 4", wb_cyc - start_cyc + 1);
    end
    checks++;
    if (pc_at_wb !== 10'd1) begin errors++; $display("FAIL add_pc: observed %h, expected 001", pc_at_wb); end
    checks++;
    if (bc != 6) begin errors++; $display("FAIL add_halt_cycles: observed %0d, expected 6", bc); end
    checks++;
    if (pc !== 10'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL halt_state: observed pc=%h busy=%b, expected 002/0", pc, busy);
    end
    checks++;
    if (wb_q.size() != 0) begin errors++; $display("FAIL add_wb_pending: observed %0d left, expected 0", wb_q.size()); end
  endtask

  task automatic test_fetch_wait();
    int n;
    do_reset();
    clear_prog();
    ack_delay = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (mem_req === 1'b1 && n < 20) begin
      checks++;
      if (mem_addr !== 10'd0 || mem_we !== 1'b0 || pc !== 10'd0) begin
        errors++;
        $display("FAIL fetch_hold: observed addr=%h we=%b pc=%h, expected 000/0/000", mem_addr, mem_we, pc);
      end
      n++;
      tick();
    end
    ack_delay = 0;
    checks++;
    if (n != 4) begin errors++; $display("FAIL fetch_wait_cycles: observed %0d, expected 4", n); end
    checks++;
    if (pc !== 10'd1) begin errors++; $display("FAIL fetch_wait_pc: observed %h, expected 001", pc); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL fetch_wait_halt: observed busy=%b, expected 0", busy); end
  endtask

  task automatic test_cmp_and_start_ignored();
    int n;
    do_reset();
    clear_prog();
    prog[0] = enc(4'b1000, 4'd3, 4'd0, 4'd0);
    prog[1] = enc(4'b0001, 4'd4, 4'd1, 4'd2);
    wb_q.push_back(wbe(4'd4, 4'd1, 4'd2, 1'b0, 4'b0010, 1'b0));
    flag_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (rf_r1 !== 4'd3) begin errors++; $display("FAIL cmp_r1: observed %h, expected 3", rf_r1); end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (flag_we !== 1'b1 || rf_we !== 1'b0) begin
      errors++; $display("FAIL cmp_exec: observed flag_we=%b rf_we=%b, expected 1/0", flag_we, rf_we);
    end
    n = 0;
    while (busy === 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (flag_cnt != 1) begin errors++; $display("FAIL cmp_flag_count: observed %0d, expected 1", flag_cnt); end
    checks++;
    if (wb_q.size() != 0 || pc !== 10'd3) begin
      errors++; $display("FAIL cmp_and_end: observed pending=%0d pc=%h, expected 0/003", wb_q.size(), pc);
    end
  endtask

  task automatic test_jumps();
    // {opcode, flags, taken}
    logic [6:0] tbl [12] = '{
      {4'b1010, 2'b01, 1'b1}, {4'b1010, 2'b11, 1'b0}, {4'b1011, 2'b00, 1'b1},
      {4'b1011, 2'b01, 1'b0}, {4'b1100, 2'b10, 1'b1}, {4'b1100, 2'b11, 1'b0},
      {4'b1101, 2'b00, 1'b1}, {4'b1101, 2'b01, 1'b1}, {4'b1101, 2'b10, 1'b0},
      {4'b1110, 2'b10, 1'b1}, {4'b1110, 2'b00, 1'b0}, {4'b1001, 2'b11, 1'b1}
    };
    int bc;
    logic [9:0] exp_pc;
    for (int i = 0; i < 12; i++) begin
      do_reset();
      clear_prog();
      prog[0] = enc_a(tbl[i][6:3], 4'd0, 10'h155);
      flags = tbl[i][2:1];
      run_prog(bc);
      exp_pc = tbl[i][0] ? 10'h156 : 10'h002;
      checks++;
      if (pc !== exp_pc || bc != 5) begin
        errors++;
        $display("FAIL jump_%0d: op=%b flags=%b observed pc=%h cycles=%0d, expected %h/5",
                 i, tbl[i][6:3], tbl[i][2:1], pc, bc, exp_pc);
      end
    end
    flags = 2'b00;
  endtask

  task automatic test_pc_wrap();
    int bc;
    do_reset();
    clear_prog();
    prog[0] = enc_a(4'b1001, 4'd0, 10'h3FF);
    run_prog(bc);
    checks++;
    if (pc !== 10'd0 || bc != 5) begin
      errors++; $display("FAIL pc_wrap: observed pc=%h cycles=%0d, expected 000/5", pc, bc);
    end
  endtask

  task automatic test_ld_st_program();
    int bc;
    do_reset();
    clear_prog();
    prog[0] = enc_a(4'b0110, 4'd5, 10'h020);
    prog[1] = enc_a(4'b0111, 4'd7, 10'h033);
    prog[2] = enc_a(4'b0100, 4'd2, {4'd6, 6'h15});
    prog[3] = enc_a(4'b0101, 4'd11, {4'd12, 6'h2A});
    prog[4] = enc(4'b0011, 4'd13, 4'd14, 4'd15);
    prog[5] = enc(4'b0010, 4'd9, 4'd3, 4'd10);
    wb_q.push_back(wbe(4'd5, 4'd0, 4'd0, 1'b1, 4'b0000, 1'b0));
    wb_q.push_back(wbe(4'd2, 4'd6, 4'd5, 1'b0, 4'b0001, 1'b1));
    wb_q.push_back(wbe(4'd11, 4'd12, 4'hA, 1'b0, 4'b0010, 1'b1));
    wb_q.push_back(wbe(4'd13, 4'd14, 4'd15, 1'b0, 4'b1000, 1'b0));
    wb_q.push_back(wbe(4'd9, 4'd3, 4'd10, 1'b0, 4'b0100, 1'b0));
    acc_q.push_back({1'b0, 10'h000});
    acc_q.push_back({1'b0, 10'h020});
    acc_q.push_back({1'b0, 10'h001});
    acc_q.push_back({1'b1, 10'h033});
    for (int a = 2; a <= 6; a++) acc_q.push_back({1'b0, 10'(a)});
    acc_chk = 1'b1;
    run_prog(bc);
    acc_chk = 1'b0;
    checks++;
    if (bc != 27) begin errors++; $display("FAIL ldst_cycles: observed %0d, expected 27", bc); end
    checks++;
    if (wb_q.size() != 0 || acc_q.size() != 0) begin
      errors++;
      $display("FAIL ldst_pending: observed wb=%0d mem=%0d left, expected 0/0", wb_q.size(), acc_q.size());
    end
    wb_q.delete();
    acc_q.delete();
  endtask

  task automatic test_reset_in_mem();
    do_reset();
    clear_prog();
    prog[0] = enc_a(4'b0110, 4'd1, 10'h040);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ack_delay = 100;
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 10'h040 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL mem_wait: observed req=%b addr=%h we=%b, expected 1/040/0", mem_req, mem_addr, mem_we);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ack_delay = 0;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || pc !== 10'd0 || ir !== 18'd0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_mem: observed busy=%b req=%b pc=%h ir=%h rf_we=%b, expected 0/0/000/00000/0",
               busy, mem_req, pc, ir, rf_we);
    end
    wb_q.delete();
  endtask

  initial begin
    clear_prog();
    test_reset();
    test_add_latency();
    test_fetch_wait();
    test_cmp_and_start_ignored();
    test_jumps();
    test_pc_wrap();
    test_ld_st_program();
    test_reset_in_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
